// File: rtl/midi_msg_parser_pkg.sv
// Shared types, status-byte constants and classification helpers for the MIDI parser.
package midi_msg_parser_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitD1,
    StWaitD2,
    StSysex
  } parse_state_e;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] ST_TUNE  = 8'hF6;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  localparam logic [3:0] HI_NOTE_OFF = 4'h8;
  localparam logic [3:0] HI_NOTE_ON  = 4'h9;

  // Channel voice/mode status: 80..EF.
  function automatic logic midi_is_chan(input logic [7:0] status);
    return status[7] && (status[7:4] != 4'hF);
  endfunction

  // Number of data bytes that follow a status byte; 0 for anything without data.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status)
          8'hF2:        len = 2'd2;
          8'hF1, 8'hF3: len = 2'd1;
          default:      len = 2'd0;
        endcase
      end
      default:                      len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, SysEx stripping, realtime split-out,
// and a single-entry valid/ready output holding register.
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter bit          VEL0_IS_OFF = 1'b1,
  parameter logic [15:0] CHAN_MASK   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_i,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       overflow,
  output logic [7:0] orphan_cnt,
  input  logic       err_clr
);

  parse_state_e r_state, w_state_d;
  logic [7:0]   r_run_status, w_run_status_d;
  logic         r_run_valid, w_run_valid_d;
  logic [7:0]   r_cur_status, w_cur_status_d;
  logic [6:0]   r_d1, w_d1_d;

  logic         r_msg_valid;
  logic [7:0]   r_msg_status;
  logic [6:0]   r_msg_data1;
  logic [6:0]   r_msg_data2;
  logic [1:0]   r_msg_len;
  logic         r_rt_valid;
  logic [7:0]   r_rt_byte;
  logic         r_overflow;
  logic [7:0]   r_orphan_cnt;

  logic         w_is_rt;
  logic [7:0]   w_frame_status;
  logic         w_emit;
  logic [7:0]   w_emit_status;
  logic [6:0]   w_emit_d1;
  logic [6:0]   w_emit_d2;
  logic [1:0]   w_emit_len;
  logic         w_orphan_evt;
  logic         w_emit_ok;
  logic         w_vel0_off;
  logic [7:0]   w_load_status;
  logic         w_can_load;
  logic         w_ovf_evt;

  assign w_is_rt = byte_valid && (byte_i >= RT_MIN);

  // In IDLE a data byte can only start a message through running status.
  assign w_frame_status = (r_state == StIdle) ? r_run_status : r_cur_status;

  // Next-state: classify the incoming byte and assemble messages.
  always_comb begin
    w_state_d      = r_state;
    w_run_status_d = r_run_status;
    w_run_valid_d  = r_run_valid;
    w_cur_status_d = r_cur_status;
    w_d1_d         = r_d1;
    w_emit         = 1'b0;
    w_emit_status  = 8'h00;
    w_emit_d1      = 7'h00;
    w_emit_d2      = 7'h00;
    w_emit_len     = 2'd0;
    w_orphan_evt   = 1'b0;

    if (byte_valid && !w_is_rt) begin
      if (byte_i[7]) begin
        if (midi_is_chan(byte_i)) begin
          w_run_status_d = byte_i;
          w_run_valid_d  = 1'b1;
          w_cur_status_d = byte_i;
          w_state_d      = StWaitD1;
        end else if (byte_i == ST_SYSEX) begin
          w_run_valid_d = 1'b0;
          w_state_d     = StSysex;
        end else if (byte_i == ST_TUNE) begin
          // Tune request carries no data; running status is left alone.
          w_emit        = 1'b1;
          w_emit_status = byte_i;
          w_state_d     = StIdle;
        end else if (midi_data_len(byte_i) != 2'd0) begin
          w_run_valid_d  = 1'b0;
          w_cur_status_d = byte_i;
          w_state_d      = StWaitD1;
        end else begin
          // F4, F5, F7 (EOX).
          w_run_valid_d = 1'b0;
          w_state_d     = StIdle;
        end
      end else begin
        unique case (r_state)
          StIdle, StWaitD1: begin
            if (r_state == StWaitD1 || r_run_valid) begin
              w_cur_status_d = w_frame_status;
              w_d1_d         = byte_i[6:0];
              if (midi_data_len(w_frame_status) == 2'd1) begin
                w_emit        = 1'b1;
                w_emit_status = w_frame_status;
                w_emit_d1     = byte_i[6:0];
                w_emit_len    = 2'd1;
                w_state_d     = midi_is_chan(w_frame_status) ? StWaitD1 : StIdle;
              end else begin
                w_state_d = StWaitD2;
              end
            end else begin
              w_orphan_evt = 1'b1;
            end
          end
          StWaitD2: begin
            w_emit        = 1'b1;
            w_emit_status = r_cur_status;
            w_emit_d1     = r_d1;
            w_emit_d2     = byte_i[6:0];
            w_emit_len    = 2'd2;
            w_state_d     = midi_is_chan(r_cur_status) ? StWaitD1 : StIdle;
          end
          StSysex: ;
          default: ;
        endcase
      end
    end
  end

  // Masked channels are parsed but never reach the output or the overflow flag.
  assign w_emit_ok = w_emit &&
                     (!midi_is_chan(w_emit_status) || CHAN_MASK[w_emit_status[3:0]]);
  assign w_vel0_off = VEL0_IS_OFF && (w_emit_status[7:4] == HI_NOTE_ON) &&
                      (w_emit_len == 2'd2) && (w_emit_d2 == 7'h00);
  assign w_load_status = w_vel0_off ? {HI_NOTE_OFF, w_emit_status[3:0]} : w_emit_status;
  assign w_can_load    = !r_msg_valid || msg_ready;
  assign w_ovf_evt     = w_emit_ok && !w_can_load;

  // Parser state and running-status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_run_status <= 8'h00;
      r_run_valid  <= 1'b0;
      r_cur_status <= 8'h00;
      r_d1         <= 7'h00;
    end else begin
      r_state      <= w_state_d;
      r_run_status <= w_run_status_d;
      r_run_valid  <= w_run_valid_d;
      r_cur_status <= w_cur_status_d;
      r_d1         <= w_d1_d;
    end
  end

  // Output holding register: load on emit when free or being drained this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_msg_valid  <= 1'b0;
      r_msg_status <= 8'h00;
      r_msg_data1  <= 7'h00;
      r_msg_data2  <= 7'h00;
      r_msg_len    <= 2'd0;
    end else if (w_emit_ok && w_can_load) begin
      r_msg_valid  <= 1'b1;
      r_msg_status <= w_load_status;
      r_msg_data1  <= w_emit_d1;
      r_msg_data2  <= w_emit_d2;
      r_msg_len    <= w_emit_len;
    end else if (r_msg_valid && msg_ready) begin
      r_msg_valid <= 1'b0;
    end
  end

  // Realtime bytes bypass the parser as a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rt_valid <= 1'b0;
      r_rt_byte  <= 8'h00;
    end else begin
      r_rt_valid <= w_is_rt;
      if (w_is_rt) begin
        r_rt_byte <= byte_i;
      end
    end
  end

  // Error flags: a same-cycle event takes precedence over err_clr.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_orphan_cnt <= 8'h00;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_orphan_evt) begin
        if (err_clr) begin
          r_orphan_cnt <= 8'd1;
        end else if (r_orphan_cnt != 8'hFF) begin
          r_orphan_cnt <= r_orphan_cnt + 8'd1;
        end
      end else if (err_clr) begin
        r_orphan_cnt <= 8'h00;
      end
    end
  end

  assign msg_valid  = r_msg_valid;
  assign msg_status = r_msg_status;
  assign msg_data1  = r_msg_data1;
  assign msg_data2  = r_msg_data2;
  assign msg_len    = r_msg_len;
  assign rt_valid   = r_rt_valid;
  assign rt_byte    = r_rt_byte;
  assign overflow   = r_overflow;
  assign orphan_cnt = r_orphan_cnt;

endmodule
